// File: rtl/sig_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sig_rom among NUM_REQ requesters, 2-edge latency.
// Define SIG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sig_rom_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  // Normally set from nn_config_pkg::sig_size by the instantiating level.
  parameter int unsigned in_width   = 8,
  parameter int unsigned data_width = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*in_width-1:0]  req_x,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [in_width-1:0]          rom_x,
  input  logic [data_width-1:0]        rom_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [data_width-1:0]        rsp_data,
  output logic                         busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0]       scan_base;
  logic [PtrW-1:0]       cand;
  logic [PtrW-1:0]       grant_idx;
  logic                  grant_vld;
  logic [NUM_REQ-1:0]    grant;

  logic [NUM_REQ-1:0]    tag_a_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [data_width-1:0] rsp_data_q;

`ifdef SIG_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign scan_base = rr_ptr_q;
`endif

  // First valid requester at or after scan_base, wrapping; nothing is granted during reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = PtrW'((32'(scan_base) + k) % NUM_REQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rom_x = '0;
    if (grant_vld) begin
      rom_x = req_x[32'(grant_idx) * in_width +: in_width];
    end
  end

  assign req_ready = grant;

  // The ROM registers rom_x on the grant edge; tag_a_q tracks whose data arrives next.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_a_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_a_q     <= grant;
      rsp_valid_q <= tag_a_q;
      if (|tag_a_q) begin
        rsp_data_q <= rom_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|tag_a_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Self-checking bench for sig_rom_arbiter: behavioural ROM stub plus a scheduled-response model.
module tb_sig_rom_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   rom_x;
  logic [D-1:0]   rom_data;
  logic [N-1:0]   rsp_valid;
  logic [D-1:0]   rsp_data;
  logic           busy;

  always #5 clk = ~clk;

  sig_rom_arbiter #(
    .NUM_REQ   (N),
    .in_width  (W),
    .data_width(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_x    (req_x),
    .req_ready(req_ready),
    .rom_x    (rom_x),
    .rom_data (rom_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  // sig_rom stub: registered read at the sign-flipped address
  logic [D-1:0] mem [256];

  function automatic logic [7:0] rom_addr(input logic [7:0] x);
    return {~x[7], x[6:0]};
  endfunction

  always @(posedge clk) rom_data <= mem[rom_addr(rom_x)];

  // Reference model: pending responses with the cycle they become visible
  typedef struct {
    int           due;
    int           req;
    logic [D-1:0] data;
  } rsp_t;

  rsp_t         pend[$];
  int           cyc;
  int           m_ptr;
  int           m_g;
  logic [D-1:0] m_last;

  logic [N-1:0] e_ready;
  logic [W-1:0] e_rom_x;
  logic [N-1:0] e_rsp_valid;
  logic [D-1:0] e_rsp_data;
  logic         e_busy;

  int n_tests;
  int n_fail;

  // Winner is the valid requester with the smallest circular distance from the pointer.
  function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (i - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N*W-1:0] rand_x();
    return (N*W)'($urandom);
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] x, input logic r);
    rst       = r;
    req_valid = v;
    req_x     = x;
    #3;
    m_g     = r ? -1 : exp_grant(v, m_ptr);
    e_ready = '0;
    e_rom_x = '0;
    if (m_g >= 0) begin
      e_ready[m_g] = 1'b1;
      e_rom_x      = x[m_g*W +: W];
    end
    e_rsp_valid = '0;
    e_busy      = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) e_rsp_valid[pend[i].req] = 1'b1;
      if (pend[i].due == cyc || pend[i].due == cyc + 1) e_busy = 1'b1;
    end
    e_rsp_data = m_last;
  endtask

  task automatic advance();
    if (rst) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due > cyc) pend.delete(i);
      end
      m_ptr  = 0;
      m_last = '0;
    end else if (m_g >= 0) begin
      pend.push_back('{cyc + 2, m_g, mem[rom_addr(req_x[m_g*W +: W])]});
`ifndef SIG_ARB_FIXED_PRIO_EN
      m_ptr = (m_g + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due < cyc) pend.delete(i);
    end
    foreach (pend[i]) begin
      if (pend[i].due == cyc) m_last = pend[i].data;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(N'($urandom), rand_x(), 1'b1);
      n_tests++;
      if ({req_ready, rom_x, rsp_valid, rsp_data, busy} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero cyc %0d: got rdy=%b x=%h rv=%b rd=%h busy=%b want all zero",
                 cyc, req_ready, rom_x, rsp_valid, rsp_data, busy);
      end
      advance();
    end
  endtask

  task automatic test_single();
    logic [N*W-1:0] x;
    int busy_cnt;
    x        = rand_x();
    x[2*W +: W] = 8'h05;
    busy_cnt = 0;
    drive(4'b0100, x, 1'b0);
    n_tests++;
    if (req_ready !== 4'b0100 || rom_x !== 8'h05) begin
      n_fail++;
      $display("FAIL single_grant: got rdy=%b x=%h want rdy=0100 x=05", req_ready, rom_x);
    end
    advance();
    for (int c = 1; c <= 3; c++) begin
      drive('0, rand_x(), 1'b0);
      if (busy === 1'b1) busy_cnt++;
      n_tests++;
      if ({req_ready, rom_x, rsp_valid, rsp_data, busy} !==
          {e_ready, e_rom_x, e_rsp_valid, e_rsp_data, e_busy}) begin
        n_fail++;
        $display("FAIL single_model c%0d: got rv=%b rd=%h busy=%b want rv=%b rd=%h busy=%b",
                 c, rsp_valid, rsp_data, busy, e_rsp_valid, e_rsp_data, e_busy);
      end
      if (c == 2) begin
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== mem[8'h85]) begin
          n_fail++;
          $display("FAIL single_rsp: got rv=%b rd=%h want rv=0100 rd=%h",
                   rsp_valid, rsp_data, mem[8'h85]);
        end
      end
      advance();
    end
    n_tests++;
    if (busy_cnt != 2) begin
      n_fail++;
      $display("FAIL single_busy_cycles: got %0d want 2", busy_cnt);
    end
  endtask

  task automatic test_contention();
    int cnt [N];
    logic [N-1:0] v;
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 0; c < 11; c++) begin
      v = (c < 8) ? {N{1'b1}} : '0;
      drive(v, rand_x(), 1'b0);
      for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) cnt[i]++;
      n_tests++;
      if ({req_ready, rom_x, rsp_valid, rsp_data, busy} !==
          {e_ready, e_rom_x, e_rsp_valid, e_rsp_data, e_busy}) begin
        n_fail++;
        $display("FAIL contention c%0d: got rdy=%b x=%h rv=%b rd=%h b=%b want rdy=%b x=%h rv=%b rd=%h b=%b",
                 c, req_ready, rom_x, rsp_valid, rsp_data, busy,
                 e_ready, e_rom_x, e_rsp_valid, e_rsp_data, e_busy);
      end
      advance();
    end
`ifndef SIG_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (cnt[i] != 2) begin
        n_fail++;
        $display("FAIL fairness req%0d: got %0d grants want 2", i, cnt[i]);
      end
    end
`endif
  endtask

  task automatic test_sparse();
    logic [N-1:0] prev;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      drive(4'b1010, rand_x(), 1'b0);
      n_tests++;
      if ({req_ready, rom_x, rsp_valid, rsp_data, busy} !==
          {e_ready, e_rom_x, e_rsp_valid, e_rsp_data, e_busy}) begin
        n_fail++;
        $display("FAIL sparse c%0d: got rdy=%b x=%h rv=%b want rdy=%b x=%h rv=%b",
                 c, req_ready, rom_x, rsp_valid, e_ready, e_rom_x, e_rsp_valid);
      end
`ifdef SIG_ARB_FIXED_PRIO_EN
      n_tests++;
      if (req_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL sparse_fixed c%0d: got %b want 0010", c, req_ready);
      end
`else
      if (prev == 4'b1000) begin
        n_tests++;
        if (req_ready !== 4'b0010) begin
          n_fail++;
          $display("FAIL sparse_wrap c%0d: got %b want 0010", c, req_ready);
        end
      end
`endif
      prev = req_ready;
      advance();
    end
  endtask

  task automatic test_midreset();
    drive(4'b0010, rand_x(), 1'b0);
    advance();
    drive('0, rand_x(), 1'b1);
    advance();
    drive(4'b1001, rand_x(), 1'b0);
    n_tests++;
    if (rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset: got rv=%b rd=%h busy=%b rdy=%b want rv=0000 rd=0000 busy=0 rdy=0001",
               rsp_valid, rsp_data, busy, req_ready);
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      drive('0, rand_x(), 1'b0);
      n_tests++;
      if ({rsp_valid, rsp_data, busy} !== {e_rsp_valid, e_rsp_data, e_busy}) begin
        n_fail++;
        $display("FAIL midreset_drain c%0d: got rv=%b rd=%h b=%b want rv=%b rd=%h b=%b",
                 c, rsp_valid, rsp_data, busy, e_rsp_valid, e_rsp_data, e_busy);
      end
      advance();
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1001, rand_x(), 1'b0);
      n_tests++;
      if (req_ready !== e_ready || rom_x !== e_rom_x) begin
        n_fail++;
        $display("FAIL priority c%0d: got rdy=%b x=%h want rdy=%b x=%h",
                 c, req_ready, rom_x, e_ready, e_rom_x);
      end
`ifdef SIG_ARB_FIXED_PRIO_EN
      n_tests++;
      if (req_ready !== 4'b0001) begin
        n_fail++;
        $display("FAIL fixed_prio c%0d: got %b want 0001", c, req_ready);
      end
`endif
      advance();
    end
  endtask

  task automatic test_boundary();
    logic [N*W-1:0] x;
    for (int c = 0; c < 5; c++) begin
      x = rand_x();
      if (c == 0) x[W-1:0] = 8'h00;
      if (c == 1) x[W-1:0] = 8'hFF;
      drive((c < 2) ? 4'b0001 : 4'b0000, x, 1'b0);
      if (c == 2 || c == 3) begin
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== mem[(c == 2) ? 8'h80 : 8'h7F]) begin
          n_fail++;
          $display("FAIL boundary c%0d: got rv=%b rd=%h want rv=0001 rd=%h",
                   c, rsp_valid, rsp_data, mem[(c == 2) ? 8'h80 : 8'h7F]);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(N'($urandom), rand_x(), ($urandom_range(0, 39) == 0));
      n_tests++;
      if ({req_ready, rom_x, rsp_valid, rsp_data, busy} !==
          {e_ready, e_rom_x, e_rsp_valid, e_rsp_data, e_busy}) begin
        n_fail++;
        $display("FAIL random c%0d: got rdy=%b x=%h rv=%b rd=%h b=%b want rdy=%b x=%h rv=%b rd=%h b=%b",
                 c, req_ready, rom_x, rsp_valid, rsp_data, busy,
                 e_ready, e_rom_x, e_rsp_valid, e_rsp_data, e_busy);
      end
      advance();
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    m_ptr     = 0;
    m_g       = -1;
    m_last    = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    for (int i = 0; i < 256; i++) mem[i] = D'($urandom);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_sparse();
    test_midreset();
    test_priority();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sig_rom_arbiter.md
# sig_rom_arbiter

- Shares a single `sig_rom` sigmoid lookup among `NUM_REQ` neuron requesters.
- Accepts at most one lookup per cycle using round-robin arbitration and drives the ROM address.
- Returns each result two clock edges after acceptance, tagged with a one-hot requester flag.
- Sits between the neuron array's activation stage and one `sig_rom` instance.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16).
- `in_width`, `sig_size` (from `nn_config_pkg`), ROM address width.
- `data_width`, 16, sigmoid result width.

Ports:
- `clk`  input  1  single clock, all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `req_valid`  input  NUM_REQ  per-requester lookup request.
- `req_x`  input  NUM_REQ*in_width  packed inputs; requester i occupies bits [i*in_width +: in_width].
- `req_ready`  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i] at a rising edge.
- `rom_x`  output  in_width  address to `sig_rom.x` (combinational).
- `rom_data`  input  data_width  from `sig_rom.output_data`.
- `rsp_valid`  output  NUM_REQ  one-hot response strobe, one cycle wide.
- `rsp_data`  output  data_width  sigmoid result for the strobed requester.
- `busy`  output  1  high while any lookup is in flight.

## Operation
- **Arbitration (combinational):**
  - Scan requesters starting at `rr_ptr`, wrapping modulo NUM_REQ.
  - The first i with req_valid[i] gets req_ready[i] = 1; all other ready bits are 0.
  - While `rst` is high, req_ready = 0.
- **Grant and address:**
  - req_ready depends only on req_valid and `rr_ptr`. There is no response backpressure.
  - Requesters must accept rsp_valid in the cycle it is asserted.
  - rom_x = req_x slice of the granted requester; rom_x = 0 when nothing is granted.
- **Pointer update:**
  - On a transfer to i, `rr_ptr` <= (i+1) mod NUM_REQ.
  - With no transfer, `rr_ptr` holds.
  - Reset value of `rr_ptr` is 0.
- **Pipeline (two registered tag stages, no data buffering):**
  - Stage A tag: on a transfer edge, `tagA` <= req_ready (one-hot); otherwise `tagA` <= 0. `sig_rom` captures rom_x on the same edge.
  - Stage B: on the next edge, `rsp_data` <= rom_data and `rsp_valid` <= `tagA`.
  - When `tagA` = 0, `rsp_data` holds its previous value.
- **Busy:** busy = |tagA | |rsp_valid.
- **Throughput:** one lookup per cycle sustained. Back-to-back responses to different or same requesters are allowed.
- **Reset:**
  - `rst` sampled high clears `tagA`, `rsp_valid`, `rsp_data` (to 0) and `rr_ptr`.
  - Lookups in flight are discarded, not replayed.

## Timing
- **Reset values:** req_ready = 0, rom_x = 0, rsp_valid = 0, rsp_data = 0, busy = 0.
- **Latency:** request accepted at edge E0; rsp_valid/rsp_data valid in the cycle after edge E1 (2 edges).
- **Fairness:** with all NUM_REQ requesting continuously, each is granted exactly once every NUM_REQ cycles.
- **Simultaneous events:**
  - A new grant and a response in the same cycle are independent.
  - A request arriving the same cycle `rst` deasserts may be granted that cycle.
- **Mid-operation reset:**
  - `rst` high at E1 suppresses the response of a lookup accepted at E0.
  - After `rst` falls, the first grant goes to the lowest-index valid requester.
- **Combinational paths:**
  - req_valid → req_ready → rom_x is combinational; requesters must not make req_valid depend on req_ready.
  - No combinational path from rom_data to any output.

## Configuration
- Macro: `SIG_ARB_FIXED_PRIO_EN`.
- Defined:
  - Fixed priority; the lowest-index valid requester always wins.
  - `rr_ptr` is not implemented.
  - The fairness guarantee does not apply; starvation of high indices is permitted.
- Undefined (default): round-robin as described above.
- Latency, ports and reset behaviour are identical in both builds.

## Test plan
- **Single request:** reset, then req_valid[2]=1 with x=0x05 for one cycle → req_ready=4'b0100 that cycle; rom_x=0x05; rsp_valid=4'b0100 two edges later with rsp_data=mem[{~x[msb],x[rest]}]; busy high for 2 cycles.
- **Full contention:** all four req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; each rsp_valid bit asserts exactly twice in the same order, offset by 2 cycles.
- **Sparse round-robin:** requesters 1 and 3 valid, after a grant to 3 → next grant is 1 (wrap), then 3.
- **Reset mid-flight:** accept a request at E0, assert rst at E1 → rsp_valid stays 0; rsp_data=0; busy=0; after release, req 3 and req 0 valid → grant to 0.
- **Fixed-priority build:** with `SIG_ARB_FIXED_PRIO_EN` defined, requesters 0 and 3 valid for 5 cycles → req_ready=4'b0001 every cycle; requester 3 never granted.
- **Boundary addresses:** x=0 and x=all-ones via requester 0 → rsp_data matches the ROM entries at mapped addresses {1,0..0} and {0,1..1}.
